// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte/word helpers: S-box ROM, xtime, Rcon, RotWord, ShiftRows map.
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef enum logic {IDLE, RUN} fsm_t;

  // Row ROM selected by the high nibble, byte picked by the low nibble (byte 0 leftmost).
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    case (b[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[{~b[3:0], 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Source byte for ShiftRows output byte i (column-major, i = row + 4*col).
  function automatic int sr_idx(input int i);
    int r, c;
    r = i % 4;
    c = i / 4;
    return r + 4 * ((c + r) % 4);
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= 10; i++)
      if (r == i[3:0]) v = RCON[i];
    return v;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round plus the matching on-the-fly key expansion step.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] next_state,
  output logic [127:0] next_rk
);

  logic [0:15][7:0] st_b, sb, sr, mc;
  logic [0:3][31:0] w, nw;
  logic [0:3][7:0]  rw_b, sw_b;
  logic [31:0]      rw, temp;

  assign st_b = state;
  assign w    = rk;

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign sb[i] = sbox(st_b[i]);
    assign sr[i] = sb[sr_idx(i)];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];
    assign mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign rw   = rot_word(w[3]);
  assign rw_b = rw;
  for (genvar j = 0; j < 4; j++) begin : g_ksb
    assign sw_b[j] = sbox(rw_b[j]);
  end
  assign temp = sw_b ^ {rcon, 24'h000000};

  assign nw[0] = w[0] ^ temp;
  assign nw[1] = w[1] ^ nw[0];
  assign nw[2] = w[2] ^ nw[1];
  assign nw[3] = w[3] ^ nw[2];

  assign next_rk    = nw;
  assign next_state = (last ? sr : mc) ^ nw;

endmodule

// File: rtl/aes128_encrypt.sv
// Iterative AES-128 forward cipher: one round per clock, start/done handshake, 11-clock latency.
module aes128_encrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] data,
  input  logic [0:127] key,
  output logic [0:127] en_key,
  output logic         done,
  output logic         busy
);

  fsm_t         fsm, fsm_nxt;
  logic [127:0] state, state_nxt, rk, rk_nxt, rnd_state, rnd_rk;
  logic [3:0]   rnd, rnd_nxt;
  logic [0:127] en_key_nxt;
  logic         done_nxt;

  aes_round u_round (
    .state      (state),
    .rk         (rk),
    .rcon       (rcon_of(rnd)),
    .last       (rnd == NR),
    .next_state (rnd_state),
    .next_rk    (rnd_rk)
  );

  assign busy = (fsm == RUN);

  always_comb begin
    fsm_nxt    = fsm;
    state_nxt  = state;
    rk_nxt     = rk;
    rnd_nxt    = rnd;
    en_key_nxt = en_key;
    done_nxt   = 1'b0;
    case (fsm)
      IDLE: begin
        if (start) begin
          state_nxt = data ^ key;
          rk_nxt    = key;
          rnd_nxt   = 4'd1;
          fsm_nxt   = RUN;
        end
      end
      RUN: begin
        state_nxt = rnd_state;
        rk_nxt    = rnd_rk;
        if (rnd == NR) begin
          en_key_nxt = rnd_state;
          done_nxt   = 1'b1;
          rnd_nxt    = 4'd0;
          fsm_nxt    = IDLE;
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // Reset also aborts an in-flight block: no done, result cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm    <= IDLE;
      state  <= '0;
      rk     <= '0;
      rnd    <= '0;
      en_key <= '0;
      done   <= 1'b0;
    end else begin
      fsm    <= fsm_nxt;
      state  <= state_nxt;
      rk     <= rk_nxt;
      rnd    <= rnd_nxt;
      en_key <= en_key_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_aes128_encrypt.sv
// Directed FIPS-197 vectors, hold/ignore, abort and back-to-back checks for aes128_encrypt.
module tb_aes128_encrypt;

  logic         clk = 1'b0;
  logic         rst_n, start, done, busy;
  logic [0:127] data, key, en_key;
  int           checks = 0, errors = 0;

  localparam logic [0:127] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_encrypt dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .data   (data),
    .key    (key),
    .en_key (en_key),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has already raised start; counts cycles until done (bounded) and busy gaps.
  task automatic wait_done(output int cyc, output int gaps);
    cyc  = 0;
    gaps = 0;
    do begin
      tick();
      start = 1'b0;
      cyc++;
      if (!done && !busy) gaps++;
    end while (!done && cyc < 30);
  endtask

  task automatic launch(input logic [0:127] pt, input logic [0:127] k);
    data  = pt;
    key   = k;
    start = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    launch(B_PT, B_KEY);
    tick();
    tick();
    checks++; if (en_key !== '0) begin errors++; $display("FAIL reset_en_key: got %h want 0", en_key); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy %b want 0", busy); end
  endtask

  task automatic test_fips_b();
    int cyc, gaps;
    launch(B_PT, B_KEY);
    wait_done(cyc, gaps);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL b_latency: got %0d want 11", cyc); end
    checks++; if (en_key !== B_CT) begin errors++; $display("FAIL b_ct: got %h want %h", en_key, B_CT); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b_busy_in_done: got %b want 0", busy); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL b_busy_gaps: got %0d want 0", gaps); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b_done_pulse: got %b want 0", done); end
    checks++; if (en_key !== B_CT) begin errors++; $display("FAIL b_hold: got %h want %h", en_key, B_CT); end
  endtask

  task automatic test_fips_c1();
    int cyc, gaps;
    launch(C_PT, C_KEY);
    wait_done(cyc, gaps);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL c1_latency: got %0d want 11", cyc); end
    checks++; if (en_key !== C_CT) begin errors++; $display("FAIL c1_ct: got %h want %h", en_key, C_CT); end
    tick();
  endtask

  task automatic test_zero();
    int cyc, gaps;
    launch('0, '0);
    wait_done(cyc, gaps);
    checks++; if (en_key !== Z_CT) begin errors++; $display("FAIL zero_ct: got %h want %h", en_key, Z_CT); end
    tick();
  endtask

  task automatic test_hold_ignore();
    int cyc, extra;
    launch(B_PT, B_KEY);
    cyc = 0;
    do begin
      tick();
      cyc++;
      start = (cyc == 4);
      if (cyc == 4) begin
        data = C_PT;
        key  = C_KEY;
      end
    end while (!done && cyc < 30);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL hold_latency: got %0d want 11", cyc); end
    checks++; if (en_key !== B_CT) begin errors++; $display("FAIL hold_ct: got %h want %h", en_key, B_CT); end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL hold_second_done: got %0d want 0", extra); end
    checks++; if (en_key !== B_CT) begin errors++; $display("FAIL hold_en_key: got %h want %h", en_key, B_CT); end
  endtask

  task automatic test_abort();
    int extra;
    launch(C_PT, C_KEY);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre: got %b want 1", busy); end
    rst_n = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (en_key !== '0) begin errors++; $display("FAIL abort_en_key: got %h want 0", en_key); end
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL abort_done: got %0d want 0", extra); end
    test_fips_c1();
  endtask

  task automatic test_back_to_back();
    int cyc, gaps;
    launch(B_PT, B_KEY);
    wait_done(cyc, gaps);
    checks++; if (en_key !== B_CT) begin errors++; $display("FAIL b2b_first: got %h want %h", en_key, B_CT); end
    launch(C_PT, C_KEY);
    wait_done(cyc, gaps);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL b2b_latency: got %0d want 11", cyc); end
    checks++; if (en_key !== C_CT) begin errors++; $display("FAIL b2b_ct: got %h want %h", en_key, C_CT); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL b2b_busy_gaps: got %0d want 0", gaps); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    data  = '0;
    key   = '0;
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_zero();
    test_hold_ignore();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
